// File: rtl/my_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package my_fetch_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/my_fetch_if.sv
// ROM request/ack bus, downstream valid/ready bus and redirect inputs of the fetch stage.
interface my_fetch_if
  import my_fetch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             jump;
  logic [WIDTH-1:0] jump_addr;
  logic [WIDTH-1:0] rom_addr;
  logic             rom_req;
  logic             rom_ack;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] inst;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_valid;
  logic             inst_ready;

  modport master (
    input  jump, jump_addr, rom_ack, rom_data, inst_ready,
    output rom_addr, rom_req, inst, inst_pc, inst_valid
  );

  modport slave (
    output jump, jump_addr, rom_ack, rom_data, inst_ready,
    input  rom_addr, rom_req, inst, inst_pc, inst_valid
  );
endinterface

// File: rtl/my_mux.sv
// Gate-library 2:1 multiplexer: y = sel ? b : a.
module my_mux (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/my_pc.sv
// Program counter register: reset > load > inc, next value selected by per-bit my_mux chains.
module my_pc #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pc
);
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] inc_sel;

  // Natural wrap of the adder gives 2^WIDTH-1 -> 0.
  assign pc_plus1 = pc_q + WIDTH'(1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    my_mux u_inc_mux (
      .a   (pc_q[i]),
      .b   (pc_plus1[i]),
      .sel (inc),
      .y   (inc_sel[i])
    );
    my_mux u_load_mux (
      .a   (inc_sel[i]),
      .b   (load_val[i]),
      .sel (load),
      .y   (pc_d[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_VAL;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;
endmodule

// File: rtl/my_fetch.sv
// Instruction-fetch stage: PC, ROM req/ack fetch, valid/ready hand-off downstream.
// Redirect (jump/jump_addr + flush) is built only when FETCH_JUMP_EN is defined.
module my_fetch
  import my_fetch_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic        clk,
  input logic        reset,
  my_fetch_if.master bus
);
  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic             rom_req_q, rom_req_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic             inst_valid_q, inst_valid_d;

  logic [WIDTH-1:0] pc_q;
  logic             pc_load;
  logic             pc_inc;
  logic             jump_w;
  logic [WIDTH-1:0] jump_addr_w;
  logic             flush_w;
  logic [WIDTH-1:0] fetch_target;

`ifdef FETCH_JUMP_EN
  logic flush_q, flush_d;
  assign jump_w      = bus.jump;
  assign jump_addr_w = bus.jump_addr;
  assign flush_w     = flush_q;
`else
  logic unused_jump;
  assign unused_jump = ^{bus.jump, bus.jump_addr};
  assign jump_w      = 1'b0;
  assign jump_addr_w = '0;
  assign flush_w     = 1'b0;
`endif

  // Address of the next request whenever the FSM (re)enters FETCH.
  assign fetch_target = jump_w ? jump_addr_w : pc_q;

  my_pc #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (jump_addr_w),
    .pc       (pc_q)
  );

  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    rom_req_d    = rom_req_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
`ifdef FETCH_JUMP_EN
    flush_d      = flush_q;
`endif
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        rom_req_d  = 1'b1;
        rom_addr_d = fetch_target;
        pc_load    = jump_w;
      end
      FETCH: begin
        if (bus.rom_ack) begin
          if (jump_w || flush_w) begin
            // Stale word: drop it and reissue at the redirect target.
            rom_addr_d = fetch_target;
            pc_load    = jump_w;
`ifdef FETCH_JUMP_EN
            flush_d    = 1'b0;
`endif
          end else begin
            inst_d       = bus.rom_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_inc       = 1'b1;
            rom_req_d    = 1'b0;
            state_d      = HOLD;
          end
        end else if (jump_w) begin
          // Request must stay stable until acked; remember to discard its data.
          pc_load = 1'b1;
`ifdef FETCH_JUMP_EN
          flush_d = 1'b1;
`endif
        end
      end
      HOLD: begin
        if (jump_w || bus.inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = FETCH;
          rom_req_d    = 1'b1;
          rom_addr_d   = fetch_target;
          pc_load      = jump_w;
        end
      end
      default: begin
        state_d   = IDLE;
        rom_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rom_addr_q   <= RESET_PC;
      rom_req_q    <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
`ifdef FETCH_JUMP_EN
      flush_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      rom_req_q    <= rom_req_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
`ifdef FETCH_JUMP_EN
      flush_q      <= flush_d;
`endif
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_req    = rom_req_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_valid_q;
endmodule
